alu: RTL and testbench



---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_if.sv | 25 ++
 rtl/alu_core.sv | 34 +++
 rtl/alu.sv | 35 +++
 tb/tb_alu.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU: opcode encoding and fixed datapath widths.
// Imported by the core, the top and the bus interface.
package alu_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 8;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_NOR  = 3'b110,
        OP_XNOR = 3'b111
    } alu_op_e;

    // Logic results live in the low nibble; the high nibble is forced to zero.
    function automatic logic [RES_W-1:0] pad_logic(input logic [OPND_W-1:0] v);
        return {{(RES_W-OPND_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between a driver of the ALU and the ALU itself.
// The master drives operands and opcode; the slave returns the registered result.
interface alu_if;
    import alu_pkg::*;

    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [OP_W-1:0]   s;
    logic [RES_W-1:0]  y;

    modport master (
        output a,
        output b,
        output s,
        input  y
    );

    modport slave (
        input  a,
        input  b,
        input  s,
        output y
    );

endinterface

// File: rtl/alu_core.sv
// Purely combinational ALU function: eight operations on two zero-extended
// 4-bit unsigned operands, producing an 8-bit result.
module alu_core
    import alu_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  alu_op_e           op,
    output logic [RES_W-1:0]  res
);

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] b_ext;

    assign a_ext = {{(RES_W-OPND_W){1'b0}}, a};
    assign b_ext = {{(RES_W-OPND_W){1'b0}}, b};

    // Subtraction wraps modulo 256, so a < b yields the two's complement value.
    always_comb begin
        res = '0;
        unique case (op)
            OP_ADD:  res = a_ext + b_ext;
            OP_SUB:  res = a_ext - b_ext;
            OP_MUL:  res = a_ext * b_ext;
            OP_AND:  res = pad_logic(a & b);
            OP_OR:   res = pad_logic(a | b);
            OP_XOR:  res = pad_logic(a ^ b);
            OP_NOR:  res = pad_logic(~(a | b));
            OP_XNOR: res = pad_logic(~(a ^ b));
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// ALU top: combinational alu_core followed by a single synchronously reset
// output register, giving one-cycle latency and one operation per cycle.
module alu
    import alu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    alu_op_e          op_p0;
    logic [RES_W-1:0] res_p0;
    logic [RES_W-1:0] y_p1;

    assign op_p0 = alu_op_e'(bus.s);

    alu_core u_core (
        .a   (bus.a),
        .b   (bus.b),
        .op  (op_p0),
        .res (res_p0)
    );

    // Stage p0 -> p1: the result register is the only state in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_p1 <= '0;
        end else begin
            y_p1 <= res_p0;
        end
    end

    assign bus.y = y_p1;

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed steps from the test plan, an exhaustive sweep
// and randomized operations with sporadic reset, against an arithmetic model.
module tb_alu;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: plain integer arithmetic reduced to the result width.
    function automatic logic [7:0] model(input int a, input int b, input int s);
        int r;
        case (s)
            0:       r = a + b;
            1:       r = (a - b + 256) % 256;
            2:       r = a * b;
            3:       r = a & b;
            4:       r = a | b;
            5:       r = a ^ b;
            6:       r = 15 - (a | b);
            default: r = 15 - (a ^ b);
        endcase
        return 8'(r);
    endfunction

    task automatic apply(input logic r, input int a, input int b, input int s);
        @(negedge clk);
        rst   = r;
        bus.a = 4'(a);
        bus.b = 4'(b);
        bus.s = 3'(s);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        checks++;
        assert (bus.y === exp)
        else begin
            errors++;
            $error("FAIL %s: y=%h expected %h", tag, bus.y, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_seq [8];
        logic [7:0] hold;
        int ra, rb, rs;
        logic rr;

        rst   = 1'b1;
        bus.a = '0;
        bus.b = '0;
        bus.s = '0;

        // Reset held for two edges with a multiply pending
        apply(1'b1, 15, 15, 2);
        check("reset_edge1", 8'h00);
        apply(1'b1, 15, 15, 2);
        check("reset_edge2", 8'h00);
        apply(1'b0, 15, 15, 2);
        check("reset_release_mul", 8'hE1);

        // Arithmetic
        apply(1'b0, 9, 3, 0);
        check("add_9_3", 8'h0C);
        apply(1'b0, 9, 11, 1);
        check("sub_9_11", 8'hFE);
        apply(1'b0, 9, 7, 2);
        check("mul_9_7", 8'h3F);

        // Logic
        apply(1'b0, 13, 11, 3);
        check("and_13_11", 8'h09);
        apply(1'b0, 11, 7, 4);
        check("or_11_7", 8'h0F);
        apply(1'b0, 10, 11, 5);
        check("xor_10_11", 8'h01);
        apply(1'b0, 14, 7, 6);
        check("nor_14_7", 8'h00);
        apply(1'b0, 5, 11, 7);
        check("xnor_5_11", 8'h01);

        // Back-to-back opcode sweep with a=9, b=3
        exp_seq = '{8'h0C, 8'h06, 8'h1B, 8'h01, 8'h0B, 8'h0A, 8'h04, 8'h05};
        for (int op = 0; op < 8; op++) begin
            apply(1'b0, 9, 3, op);
            check($sformatf("b2b_op%0d", op), exp_seq[op]);
        end

        // Inputs changed between edges must not disturb y
        hold = bus.y;
        #2;
        bus.a = 4'd15;
        bus.b = 4'd15;
        bus.s = 3'd2;
        #1;
        check("no_glitch_between_edges", hold);

        // Mid-stream reset for exactly one edge
        apply(1'b0, 12, 4, 0);
        check("mid_before", 8'h10);
        apply(1'b1, 6, 5, 2);
        check("mid_reset", 8'h00);
        apply(1'b0, 6, 5, 2);
        check("mid_after", 8'h1E);

        // Boundaries: zero operands and max underflow
        apply(1'b0, 0, 15, 1);
        check("sub_0_15", 8'hF1);
        apply(1'b0, 0, 0, 6);
        check("nor_0_0", 8'h0F);
        apply(1'b0, 15, 15, 0);
        check("add_15_15", 8'h1E);

        // Exhaustive sweep
        for (int s = 0; s < 8; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    apply(1'b0, a, b, s);
                    check($sformatf("exh_a%0d_b%0d_s%0d", a, b, s), model(a, b, s));
                end
            end
        end

        // Randomized operations with occasional reset
        for (int i = 0; i < 500; i++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            rs = int'($urandom_range(0, 7));
            rr = ($urandom_range(0, 15) == 0);
            apply(rr, ra, rb, rs);
            check($sformatf("rnd%0d_a%0d_b%0d_s%0d_r%0d", i, ra, rb, rs, rr),
                  rr ? 8'h00 : model(ra, rb, rs));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
